// File: rtl/mem_arbiter_riscv_defines.sv
// Shared definitions for the instruction/data memory arbiter.
//   arb_state_t : arbiter FSM states (idle, fetch in flight, data in flight)
//   SIZE_*      : access size codes carried on d_size / mem_size
package mem_arbiter_riscv_defines;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        D_BUSY  = 2'd2
    } arb_state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a data port onto one memory port, with at most
// one memory access outstanding.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   if_req/if_addr                 fetch request in
//   if_gnt/if_rvalid/if_rdata      fetch grant, completion pulse, read data
//   d_req/d_we/d_addr/d_wdata/d_size  data request in
//   d_gnt/d_rvalid/d_rdata         data grant, completion pulse, load data
//   mem_req/mem_we/mem_addr/mem_wdata/mem_size  unified memory request out
//   mem_ready/mem_rdata            memory completion and read data in
//   dbg_state                      current FSM state, for observation
//
// Handshake: a requester holds req and its fields until it sees gnt (a
// one-cycle combinational pulse in IDLE); the fields are captured on that
// edge. mem_req and the mem_* fields are held from the next cycle until the
// cycle mem_ready is high; the owner's rvalid pulses one cycle later.
module mem_arbiter
    import mem_arbiter_riscv_defines::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req,
    input  logic [DATA_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [DATA_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    input  logic [1:0]            d_size,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [1:0]            mem_size,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output arb_state_t            dbg_state
);

    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    arb_state_t            state_q, state_d;
    logic [CNT_W-1:0]      starve_q, starve_d;
    logic                  we_q, we_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [1:0]            size_q, size_d;
    logic                  if_rvalid_q, if_rvalid_d;
    logic                  d_rvalid_q, d_rvalid_d;
    logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
    logic                  grant_if, grant_d;

    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        size_d      = size_q;
        if_rvalid_d = 1'b0;
        d_rvalid_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        grant_if    = 1'b0;
        grant_d     = 1'b0;

        case (state_q)
            IDLE: begin
                // Data normally wins; fetch wins once data has starved it
                // for STARVE_LIMIT consecutive grants.
                if (if_req && (!d_req || starve_q == STARVE_MAX)) begin
                    grant_if = 1'b1;
                end else if (d_req) begin
                    grant_d = 1'b1;
                end

                if (grant_if) begin
                    state_d  = IF_BUSY;
                    addr_d   = if_addr;
                    wdata_d  = '0;
                    we_d     = 1'b0;
                    size_d   = SIZE_WORD;
                    starve_d = '0;
                end else if (grant_d) begin
                    state_d = D_BUSY;
                    addr_d  = d_addr;
                    wdata_d = d_wdata;
                    we_d    = d_we;
                    size_d  = d_size;
                    if (!if_req) begin
                        starve_d = '0;
                    end else if (starve_q != STARVE_MAX) begin
                        starve_d = starve_q + CNT_W'(1);
                    end
                end else if (!if_req) begin
                    starve_d = '0;
                end
            end
            IF_BUSY: begin
                if (mem_ready) begin
                    if_rvalid_d = 1'b1;
                    if_rdata_d  = mem_rdata;
                    state_d     = IDLE;
                end
            end
            D_BUSY: begin
                if (mem_ready) begin
                    d_rvalid_d = 1'b1;
                    // Store completions leave the load data register alone.
                    if (!we_q) begin
                        d_rdata_d = mem_rdata;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            starve_q    <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            size_q      <= '0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            size_q      <= size_d;
            if_rvalid_q <= if_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    // Grants are combinational; gating with rst_n keeps them low while reset
    // is held even though the state register already reads IDLE.
    assign if_gnt    = grant_if && rst_n;
    assign d_gnt     = grant_d && rst_n;
    assign if_rvalid = if_rvalid_q;
    assign d_rvalid  = d_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign mem_req   = (state_q != IDLE);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_size  = size_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  import mem_arbiter_riscv_defines::*;

  localparam int DW = 32;
  localparam int SL = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req, if_gnt, if_rvalid;
  logic [DW-1:0] if_addr, if_rdata;
  logic          d_req, d_we, d_gnt, d_rvalid;
  logic [DW-1:0] d_addr, d_wdata, d_rdata;
  logic [1:0]    d_size;
  logic          mem_req, mem_we, mem_ready;
  logic [DW-1:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]    mem_size;
  arb_state_t    dbg_state;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [DW-1:0] exp_if_rdata = '0;
  logic [DW-1:0] exp_d_rdata = '0;

  mem_arbiter #(.DATA_WIDTH(DW), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_size(d_size), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_size(mem_size),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_size = SIZE_BYTE;
    mem_ready = 1'b0;
  endtask

  task automatic drain();
    idle_inputs();
    mem_ready = 1'b1;
    repeat (3) cyc();
    mem_ready = 1'b0;
  endtask

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    // local compare used by directed tests
    total_cnt++;
    if (got !== exp) $display("FAIL %s: got %h required %h", name, got, exp);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    if_req = 1'b1; if_addr = 32'h40;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h50; d_wdata = 32'h1; d_size = SIZE_WORD;
    mem_ready = 1'b1; mem_rdata = 32'hA5A5_0001;
    smp();
    total_cnt++;
    if ({if_gnt, d_gnt, if_rvalid, d_rvalid, mem_req, mem_we} !== 6'b0)
      $display("FAIL reset_ctrl: got %b required 000000", {if_gnt, d_gnt, if_rvalid, d_rvalid, mem_req, mem_we});
    else pass_cnt++;
    total_cnt++;
    if ({if_rdata, d_rdata, mem_addr, mem_wdata, mem_size} !== '0)
      $display("FAIL reset_data: got %h %h %h %h %h required zeros", if_rdata, d_rdata, mem_addr, mem_wdata, mem_size);
    else pass_cnt++;
    total_cnt++;
    if (dbg_state !== IDLE) $display("FAIL reset_state: got %0d required %0d", dbg_state, IDLE);
    else pass_cnt++;
    // release and take a data load on the first edge
    @(posedge clk); #1;
    rst_n = 1'b1;
    if_req = 1'b0;
    smp();
    total_cnt++;
    if ({if_gnt, d_gnt} !== 2'b01) $display("FAIL first_grant: got %b required 01", {if_gnt, d_gnt});
    else pass_cnt++;
    cyc();
    d_req = 1'b0;
    smp();
    total_cnt++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h50}) $display("FAIL first_memreq: got %b %h required 1 00000050", mem_req, mem_addr);
    else pass_cnt++;
    cyc();
    smp();
    total_cnt++;
    if ({d_rvalid, d_rdata} !== {1'b1, 32'hA5A5_0001}) $display("FAIL first_load: got %b %h required 1 a5a50001", d_rvalid, d_rdata);
    else pass_cnt++;
    exp_d_rdata = 32'hA5A5_0001;
    drain();
  endtask

  task automatic test_fetch_only();
    if_req = 1'b1; if_addr = 32'h10; mem_ready = 1'b1; mem_rdata = 32'h13;
    smp();
    total_cnt++;
    if ({if_gnt, d_gnt} !== 2'b10) $display("FAIL fetch_gnt: got %b required 10", {if_gnt, d_gnt});
    else pass_cnt++;
    cyc();
    if_req = 1'b0;
    smp();
    total_cnt++;
    if ({mem_req, mem_we, mem_size, mem_addr} !== {1'b1, 1'b0, SIZE_WORD, 32'h10})
      $display("FAIL fetch_mem: got %b %b %b %h required 1 0 10 00000010", mem_req, mem_we, mem_size, mem_addr);
    else pass_cnt++;
    cyc();
    smp();
    total_cnt++;
    if ({if_rvalid, d_rvalid, if_rdata, mem_req} !== {1'b1, 1'b0, 32'h13, 1'b0})
      $display("FAIL fetch_rvalid: got %b %b %h %b required 1 0 00000013 0", if_rvalid, d_rvalid, if_rdata, mem_req);
    else pass_cnt++;
    exp_if_rdata = 32'h13;
    cyc();
    smp();
    total_cnt++;
    if ({if_rvalid, if_rdata} !== {1'b0, exp_if_rdata}) $display("FAIL fetch_hold: got %b %h required 0 %h", if_rvalid, if_rdata, exp_if_rdata);
    else pass_cnt++;
    drain();
  endtask

  task automatic test_simultaneous();
    if_req = 1'b1; if_addr = 32'h20;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_size = SIZE_WORD;
    mem_ready = 1'b1; mem_rdata = 32'h7777_7777;
    smp();
    total_cnt++;
    if ({if_gnt, d_gnt} !== 2'b01) $display("FAIL sim_gnt: got %b required 01", {if_gnt, d_gnt});
    else pass_cnt++;
    cyc();
    d_req = 1'b0;
    smp();
    total_cnt++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, mem_size, if_gnt} !== {1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, SIZE_WORD, 1'b0})
      $display("FAIL sim_store: got %b %b %h %h %b %b required 1 1 00000100 deadbeef 10 0", mem_req, mem_we, mem_addr, mem_wdata, mem_size, if_gnt);
    else pass_cnt++;
    cyc();
    smp();
    total_cnt++;
    if ({d_rvalid, if_rvalid, d_rdata, if_gnt} !== {1'b1, 1'b0, exp_d_rdata, 1'b1})
      $display("FAIL sim_done: got %b %b %h %b required 1 0 %h 1", d_rvalid, if_rvalid, d_rdata, if_gnt, exp_d_rdata);
    else pass_cnt++;
    cyc();
    if_req = 1'b0;
    smp();
    total_cnt++;
    if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h20}) $display("FAIL sim_fetch: got %b %b %h required 1 0 00000020", mem_req, mem_we, mem_addr);
    else pass_cnt++;
    exp_if_rdata = 32'h7777_7777;
    drain();
  endtask

  task automatic test_starvation();
    int gcount = 0;
    int overlap = 0;
    logic exp_fetch;
    if_req = 1'b1; if_addr = 32'h300;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400; d_size = SIZE_WORD;
    mem_ready = 1'b1; mem_rdata = 32'h5555;
    for (int c = 0; c < 30; c++) begin
      smp();
      if ((if_gnt && d_gnt) || (if_rvalid && d_rvalid)) overlap++;
      if (if_gnt || d_gnt) begin
        exp_fetch = ((gcount % (SL + 1)) == SL);
        total_cnt++;
        if ({if_gnt, d_gnt} !== {exp_fetch, !exp_fetch})
          $display("FAIL starve_grant%0d: got %b required %b", gcount, {if_gnt, d_gnt}, {exp_fetch, !exp_fetch});
        else pass_cnt++;
        gcount++;
      end
      cyc();
    end
    total_cnt++;
    if (gcount !== 15) $display("FAIL starve_count: got %0d required 15", gcount);
    else pass_cnt++;
    total_cnt++;
    if (overlap !== 0) $display("FAIL starve_overlap: got %0d required 0", overlap);
    else pass_cnt++;
    exp_if_rdata = 32'h5555;
    exp_d_rdata = 32'h5555;
    drain();
  endtask

  task automatic test_wait_states();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h44; d_wdata = 32'h1234_5678; d_size = SIZE_HALF;
    mem_ready = 1'b0; mem_rdata = 32'h9999_0000;
    smp();
    total_cnt++;
    if (d_gnt !== 1'b1) $display("FAIL wait_gnt: got %b required 1", d_gnt);
    else pass_cnt++;
    cyc();
    d_req = 1'b0;
    for (int w = 0; w < 3; w++) begin
      smp();
      total_cnt++;
      if ({mem_req, mem_addr, mem_wdata, mem_size, d_rvalid} !== {1'b1, 32'h44, 32'h1234_5678, SIZE_HALF, 1'b0})
        $display("FAIL wait_hold%0d: got %b %h %h %b %b required 1 00000044 12345678 01 0", w, mem_req, mem_addr, mem_wdata, mem_size, d_rvalid);
      else pass_cnt++;
      cyc();
    end
    mem_ready = 1'b1;
    smp();
    total_cnt++;
    if ({mem_req, d_rvalid} !== 2'b10) $display("FAIL wait_ready: got %b required 10", {mem_req, d_rvalid});
    else pass_cnt++;
    cyc();
    mem_ready = 1'b0;
    smp();
    total_cnt++;
    if ({d_rvalid, d_rdata} !== {1'b1, exp_d_rdata}) $display("FAIL wait_done: got %b %h required 1 %h", d_rvalid, d_rdata, exp_d_rdata);
    else pass_cnt++;
    cyc();
    smp();
    total_cnt++;
    if (d_rvalid !== 1'b0) $display("FAIL wait_single: got %b required 0", d_rvalid);
    else pass_cnt++;
    drain();
  endtask

  task automatic test_reset_mid_op();
    int rv = 0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80; d_size = SIZE_WORD; mem_ready = 1'b0;
    smp();
    cyc();
    d_req = 1'b0;
    smp();
    total_cnt++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h80}) $display("FAIL midop_busy: got %b %h required 1 00000080", mem_req, mem_addr);
    else pass_cnt++;
    #1;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({mem_req, mem_we, mem_addr, mem_size, d_rdata, if_rdata, d_gnt} !== '0)
      $display("FAIL midop_async: got %b %b %h %b %h %h %b required zeros", mem_req, mem_we, mem_addr, mem_size, d_rdata, if_rdata, d_gnt);
    else pass_cnt++;
    exp_if_rdata = '0;
    exp_d_rdata = '0;
    mem_ready = 1'b1;
    repeat (2) begin
      smp();
      if (d_rvalid) rv++;
      cyc();
    end
    rst_n = 1'b1;
    mem_ready = 1'b0;
    if_req = 1'b1; if_addr = 32'h200;
    smp();
    if (d_rvalid) rv++;
    total_cnt++;
    if (rv !== 0) $display("FAIL midop_no_rvalid: got %0d required 0", rv);
    else pass_cnt++;
    total_cnt++;
    if (if_gnt !== 1'b1) $display("FAIL midop_regrant: got %b required 1", if_gnt);
    else pass_cnt++;
    cyc();
    if_req = 1'b0;
    smp();
    total_cnt++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h200}) $display("FAIL midop_fetch: got %b %h required 1 00000200", mem_req, mem_addr);
    else pass_cnt++;
    mem_rdata = 32'h0;
    exp_if_rdata = 32'h0;
    drain();
  endtask

  // Random traffic against a transaction-level model: an owner (0 none,
  // 1 fetch, 2 data) with its captured request, a pending completion, and a
  // starvation tally updated by the priority rules.
  task automatic test_random();
    int owner = 0;
    int pend = 0;
    int starve = 0;
    logic [DW-1:0] t_addr, t_wdata;
    logic t_we;
    logic [1:0] t_size;
    logic e_if, e_d, if_hit, d_hit;
    if_hit = 1'b0; d_hit = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!if_req || if_hit) begin
        if_req = ($urandom_range(0, 2) != 0); if_addr = $urandom;
      end else if ($urandom_range(0, 9) == 0) if_req = 1'b0;
      if (!d_req || d_hit) begin
        d_req = ($urandom_range(0, 2) != 0); d_we = $urandom_range(0, 1) == 1;
        d_addr = $urandom; d_wdata = $urandom; d_size = 2'($urandom_range(0, 2));
      end else if ($urandom_range(0, 9) == 0) d_req = 1'b0;
      mem_ready = ($urandom_range(0, 2) != 0);
      mem_rdata = $urandom;
      smp();
      e_if = (owner == 0) && if_req && (!d_req || starve == SL);
      e_d = (owner == 0) && d_req && !e_if;
      total_cnt++;
      if ({if_gnt, d_gnt} !== {e_if, e_d}) $display("FAIL rnd_gnt c%0d: got %b required %b", c, {if_gnt, d_gnt}, {e_if, e_d});
      else pass_cnt++;
      total_cnt++;
      if (mem_req !== (owner != 0)) $display("FAIL rnd_memreq c%0d: got %b required %b", c, mem_req, owner != 0);
      else pass_cnt++;
      if (owner == 2) begin
        total_cnt++;
        if ({mem_we, mem_addr, mem_wdata, mem_size} !== {t_we, t_addr, t_wdata, t_size})
          $display("FAIL rnd_dfields c%0d: got %b %h %h %b required %b %h %h %b", c, mem_we, mem_addr, mem_wdata, mem_size, t_we, t_addr, t_wdata, t_size);
        else pass_cnt++;
      end else if (owner == 1) begin
        total_cnt++;
        if ({mem_we, mem_addr, mem_size} !== {1'b0, t_addr, SIZE_WORD})
          $display("FAIL rnd_ifields c%0d: got %b %h %b required 0 %h 10", c, mem_we, mem_addr, mem_size, t_addr);
        else pass_cnt++;
      end
      total_cnt++;
      if ({if_rvalid, d_rvalid} !== {pend == 1, pend == 2}) $display("FAIL rnd_rvalid c%0d: got %b required %b", c, {if_rvalid, d_rvalid}, {pend == 1, pend == 2});
      else pass_cnt++;
      total_cnt++;
      if ({if_rdata, d_rdata} !== {exp_if_rdata, exp_d_rdata})
        $display("FAIL rnd_rdata c%0d: got %h %h required %h %h", c, if_rdata, d_rdata, exp_if_rdata, exp_d_rdata);
      else pass_cnt++;
      // model advance across the coming edge
      pend = 0;
      if (owner == 0) begin
        if (e_if) begin
          owner = 1; t_addr = if_addr; starve = 0;
        end else if (e_d) begin
          owner = 2; t_addr = d_addr; t_wdata = d_wdata; t_we = d_we; t_size = d_size;
          starve = if_req ? ((starve < SL) ? starve + 1 : SL) : 0;
        end else if (!if_req) starve = 0;
      end else if (mem_ready) begin
        pend = owner;
        if (owner == 1) exp_if_rdata = mem_rdata;
        else if (!t_we) exp_d_rdata = mem_rdata;
        owner = 0;
      end
      if_hit = e_if; d_hit = e_d;
      cyc();
    end
    drain();
  endtask

  // sequence and report
  initial begin
    rst_n = 1'b0;
    idle_inputs();
    mem_rdata = '0;
    test_reset();
    test_fetch_only();
    test_simultaneous();
    test_starvation();
    test_wait_states();
    test_reset_mid_op();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
